// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline latches: stage state encoding and
// the instruction NOP used to fill squashed instruction latches.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipe_skid_entry.sv
// One payload register of a skid stage: synchronous clear to FLUSH_VALUE,
// otherwise loads d when load is high and holds when it is low.
module pipe_skid_entry
   import pipe_pkg::*;
#(
   parameter int unsigned          DATA_SIZE   = 16,
   parameter logic [DATA_SIZE-1:0] FLUSH_VALUE = {DATA_SIZE{1'b0}}
) (
   input  logic                 clk,
   input  logic                 clear,
   input  logic                 load,
   input  logic [DATA_SIZE-1:0] d,
   output logic [DATA_SIZE-1:0] q
);

   always_ff @(posedge clk) begin
      if (clear) begin
         q <= FLUSH_VALUE;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready pipeline register with flush. The main entry drives
// out_data; the skid entry catches the word that arrives while stalled.
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int unsigned          DATA_SIZE   = 16,
   parameter logic [DATA_SIZE-1:0] FLUSH_VALUE = {DATA_SIZE{1'b0}}
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [DATA_SIZE-1:0] in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [DATA_SIZE-1:0] out_data,
   input  logic                 out_ready,
   output logic [1:0]           occupancy
);

   state_e               state_q, state_d;
   logic                 clear;
   logic                 accept, consume;
   logic                 main_load, skid_load, main_from_skid;
   logic [DATA_SIZE-1:0] main_d, main_q, skid_q;

   // Handshake flags decode straight from the state flop, never from in_*.
   assign in_ready  = (state_q != ST_FULL);
   assign out_valid = (state_q != ST_EMPTY);
   assign occupancy = state_q;

   assign clear   = rst | flush;
   assign accept  = in_valid & in_ready;
   assign consume = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      skid_load      = 1'b0;
      main_from_skid = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d   = ST_ONE;
               main_load = 1'b1;
            end
         end
         ST_ONE: begin
            if (consume && accept) begin
               main_load = 1'b1;
            end else if (consume) begin
               // Main keeps the consumed word; out_valid alone marks it stale.
               state_d = ST_EMPTY;
            end else if (accept) begin
               state_d   = ST_FULL;
               skid_load = 1'b1;
            end
         end
         ST_FULL: begin
            if (consume) begin
               state_d        = ST_ONE;
               main_load      = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   assign main_d   = main_from_skid ? skid_q : in_data;
   assign out_data = main_q;

   pipe_skid_entry #(
      .DATA_SIZE   (DATA_SIZE),
      .FLUSH_VALUE (FLUSH_VALUE)
   ) u_main (
      .clk   (clk),
      .clear (clear),
      .load  (main_load),
      .d     (main_d),
      .q     (main_q)
   );

   pipe_skid_entry #(
      .DATA_SIZE   (DATA_SIZE),
      .FLUSH_VALUE (FLUSH_VALUE)
   ) u_skid (
      .clk   (clk),
      .clear (clear),
      .load  (skid_load),
      .d     (in_data),
      .q     (skid_q)
   );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, a queue-based random model
// run on the 16-bit instance, and a short 37-bit width sequence.
module tb_pipe_skid_reg;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // 16-bit instance
   logic        rst, flush, in_valid, out_ready;
   logic [15:0] in_data;
   logic        in_ready, out_valid;
   logic [15:0] out_data;
   logic [1:0]  occupancy;

   // 37-bit instance
   localparam logic [36:0] WFV = 37'h1_2345_6789;
   logic        w_rst, w_flush, w_in_valid, w_out_ready;
   logic [36:0] w_in_data;
   logic        w_in_ready, w_out_valid;
   logic [36:0] w_out_data;
   logic [1:0]  w_occupancy;

   pipe_skid_reg dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .occupancy (occupancy)
   );

   pipe_skid_reg #(
      .DATA_SIZE   (37),
      .FLUSH_VALUE (WFV)
   ) dut_w (
      .clk       (clk),
      .rst       (w_rst),
      .flush     (w_flush),
      .in_valid  (w_in_valid),
      .in_data   (w_in_data),
      .in_ready  (w_in_ready),
      .out_valid (w_out_valid),
      .out_data  (w_out_data),
      .out_ready (w_out_ready),
      .occupancy (w_occupancy)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst, flush, iv;
      logic [15:0] d;
      logic        ordy;
      logic        ev, er;
      logic [1:0]  eocc;
      logic [15:0] ed;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic f, logic iv, logic [15:0] d, logic o,
                               logic ev, logic er, logic [1:0] eocc, logic [15:0] ed);
      vec_t v;
      v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.ordy = o;
      v.ev = ev; v.er = er; v.eocc = eocc; v.ed = ed;
      return v;
   endfunction

   // Reference model: FIFO of at most two words plus the last head value.
   logic [15:0] mq[$];
   logic [15:0] mhead;

   task automatic model_step(input logic r, input logic f, input logic iv,
                             input logic [15:0] d, input logic o);
      bit can_take, has_word;
      can_take = (mq.size() < 2);
      has_word = (mq.size() > 0);
      if (r || f) begin
         mq.delete();
         mhead = 16'h0000;
      end else begin
         if (has_word && o) void'(mq.pop_front());
         if (iv && can_take) mq.push_back(d);
         if (mq.size() > 0) mhead = mq[0];
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      w_rst = 1'b1; w_flush = 1'b0; w_in_valid = 1'b0; w_in_data = '0; w_out_ready = 1'b0;

      // Reset for two cycles
      tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 1, 0, 16'h0000));
      tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 1, 0, 16'h0000));
      // Streaming 1..8 with a ready downstream
      for (int i = 1; i <= 8; i++)
         tbl.push_back(mk(0, 0, 1, 16'(i), 1, 1, 1, 1, 16'(i)));
      tbl.push_back(mk(0, 0, 0, 16'hDEAD, 1, 0, 1, 0, 16'h0008));
      // Stall fill, then drain in order
      tbl.push_back(mk(0, 0, 1, 16'h1111, 0, 1, 1, 1, 16'h1111));
      tbl.push_back(mk(0, 0, 1, 16'h2222, 0, 1, 0, 2, 16'h1111));
      tbl.push_back(mk(0, 0, 1, 16'h3333, 0, 1, 0, 2, 16'h1111));
      tbl.push_back(mk(0, 0, 1, 16'h3333, 1, 1, 1, 1, 16'h2222));
      tbl.push_back(mk(0, 0, 1, 16'h3333, 1, 1, 1, 1, 16'h3333));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h3333));
      // Flush while FULL drops both words and the offered one
      tbl.push_back(mk(0, 0, 1, 16'hAAAA, 0, 1, 1, 1, 16'hAAAA));
      tbl.push_back(mk(0, 0, 1, 16'hBBBB, 0, 1, 0, 2, 16'hAAAA));
      tbl.push_back(mk(0, 1, 1, 16'hCCCC, 1, 0, 1, 0, 16'h0000));
      tbl.push_back(mk(0, 0, 0, 16'hCCCC, 1, 0, 1, 0, 16'h0000));
      // Reset together with flush, accept and consume in ONE
      tbl.push_back(mk(0, 0, 1, 16'h1234, 0, 1, 1, 1, 16'h1234));
      tbl.push_back(mk(1, 1, 1, 16'h5678, 1, 0, 1, 0, 16'h0000));
      // Simultaneous consume and accept in ONE
      tbl.push_back(mk(0, 0, 1, 16'h0F0F, 0, 1, 1, 1, 16'h0F0F));
      tbl.push_back(mk(0, 0, 1, 16'hF0F0, 1, 1, 1, 1, 16'hF0F0));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 1, 0, 16'hF0F0));

      foreach (tbl[i]) begin
         rst = tbl[i].rst; flush = tbl[i].flush; in_valid = tbl[i].iv;
         in_data = tbl[i].d; out_ready = tbl[i].ordy;
         @(posedge clk); #1;
         chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tbl[i].ev));
         chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(tbl[i].er));
         chk($sformatf("vec%0d occupancy", i), 64'(occupancy), 64'(tbl[i].eocc));
         chk($sformatf("vec%0d out_data", i), 64'(out_data), 64'(tbl[i].ed));
      end

      // Random traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         rst       = (i == 0) || ($urandom_range(0, 59) == 0);
         flush     = ($urandom_range(0, 39) == 0);
         in_valid  = $urandom_range(0, 1);
         in_data   = 16'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         model_step(rst, flush, in_valid, in_data, out_ready);
         @(posedge clk); #1;
         chk($sformatf("rnd%0d out_valid", i), 64'(out_valid), 64'(mq.size() > 0));
         chk($sformatf("rnd%0d in_ready", i), 64'(in_ready), 64'(mq.size() < 2));
         chk($sformatf("rnd%0d occupancy", i), 64'(occupancy), 64'(mq.size()));
         chk($sformatf("rnd%0d out_data", i), 64'(out_data), 64'(mhead));
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

      // 37-bit width sequence
      @(posedge clk); #1;
      chk("wide reset out_data", 64'(w_out_data), 64'(WFV));
      chk("wide reset out_valid", 64'(w_out_valid), 64'd0);
      w_rst = 1'b0;
      w_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         logic [36:0] wd;
         wd = 37'h1F_0000_0000 | 37'(i + 1) | (37'(i) << 20);
         w_in_valid = 1'b1;
         w_in_data  = wd;
         @(posedge clk); #1;
         chk($sformatf("wide%0d out_data", i), 64'(w_out_data), 64'(wd));
         chk($sformatf("wide%0d occupancy", i), 64'(w_occupancy), 64'd1);
      end
      w_in_valid = 1'b0;
      w_flush = 1'b1;
      @(posedge clk); #1;
      chk("wide flush out_data", 64'(w_out_data), 64'(WFV));
      chk("wide flush in_ready", 64'(w_in_ready), 64'd1);
      w_flush = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised elastic pipeline register for inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) in the pipelined processor.
- Replaces the plain enable-register latch with a two-entry valid/ready stage.
- Stage-local stall via back-pressure, flush with bubble insertion, and a skid entry, so a stall never loses the word already in flight.
- Fully registered outputs; one-cycle forward latency.

Parameters:
DATA_SIZE, 16, width of the payload bus in bits.
FLUSH_VALUE, {DATA_SIZE{1'b0}}, value out_data takes after reset or flush (encoded NOP for instruction latches).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
flush  input  1  synchronous squash of both entries (branch mispredict / exception).
in_valid  input  1  upstream presents a word on in_data.
in_data  input  DATA_SIZE  upstream payload.
in_ready  output  1  stage can accept a word this cycle; registered.
out_valid  output  1  out_data holds a valid word; registered.
out_data  output  DATA_SIZE  head-of-stage payload; registered.
out_ready  input  1  downstream consumes the head word this cycle.
occupancy  output  2  number of valid entries, 0..2.

Behaviour:
- Interface is fixed: one clock (clk); reset is synchronous and active-high (rst).
- Transfer rules:
  - Accept occurs when in_valid && in_ready.
  - Consume occurs when out_valid && out_ready.
  - out_ready is ignored while out_valid=0.
- Storage: main entry (drives out_data) and skid entry. Words leave in arrival order.
- States: EMPTY (occupancy 0), ONE (main valid), FULL (main and skid valid).
- Outputs: in_ready = (state != FULL); out_valid = (state != EMPTY). Both come from state flops, with no combinational path from in_* to out_*.
- Transitions when neither rst nor flush is asserted:
  - EMPTY + accept -> ONE; main <= in_data.
  - EMPTY, no accept -> EMPTY; out_data holds its last value.
  - ONE, consume && accept -> ONE; main <= in_data.
  - ONE, consume && !accept -> EMPTY; main data is held, not cleared.
  - ONE, !consume && accept -> FULL; skid <= in_data.
  - ONE, no consume, no accept -> ONE; hold.
  - FULL, consume -> ONE; main <= skid. No accept is possible, since in_ready=0.
  - FULL, no consume -> FULL; hold.
- Latency: a word accepted at edge N is visible on out_data with out_valid=1 after edge N. With a continuously ready downstream, throughput is 1 word/cycle.
- Reset (rst=1), regardless of other inputs: state -> EMPTY, main and skid <= FLUSH_VALUE, out_valid=0, in_ready=1, occupancy=0.
- Flush (flush=1, rst=0): same effect as reset. Flush has priority over a same-cycle accept or consume: the offered input word is dropped and the consumed word is not re-presented. in_ready=1 on the following cycle.
- rst and flush asserted together: reset semantics, which are identical.
- Reset or flush while FULL: both words are discarded and no partial state survives.
- in_data is sampled only on accept. X on in_data while in_valid=0 must not propagate.
- occupancy encodes EMPTY=0, ONE=1, FULL=2; the value 3 is never produced.

Decomposition:
- Shared package (pipe_pkg) holds:
  - State encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - The NOP encoding constant used as FLUSH_VALUE by instruction latches.
- One sub-module: pipe_skid_entry, a DATA_SIZE-wide register with synchronous reset-to-FLUSH_VALUE and load enable. It is instantiated twice (main, skid).
- The FSM and next-data muxing live in pipe_skid_reg.

Test Plan:
- Streaming: rst for 2 cycles, then in_valid=1 with in_data=0x0001..0x0008 on consecutive cycles and out_ready=1 -> out_data 0x0001..0x0008 each one cycle after accept; occupancy stays 1; in_ready stays 1.
- Stall fill: accept 0x1111, hold out_ready=0, offer 0x2222 then 0x3333 -> 0x2222 accepted and occupancy=2, in_ready=0 so 0x3333 is held upstream. Raise out_ready -> outputs 0x1111, 0x2222, 0x3333 in order, none lost or duplicated.
- Flush while FULL: main=0xAAAA, skid=0xBBBB, flush=1 with in_valid=1, in_data=0xCCCC -> next cycle out_valid=0, occupancy=0, out_data=FLUSH_VALUE, in_ready=1; 0xCCCC never appears.
- Reset priority: rst=1 with flush=1, in_valid=1, out_ready=1 in state ONE -> EMPTY, out_data=FLUSH_VALUE, in_ready=1.
- Simultaneous consume+accept in ONE: main=0x0F0F, out_ready=1, accept 0xF0F0 -> next cycle out_data=0xF0F0, occupancy=1.
- Width check: DATA_SIZE=37, FLUSH_VALUE=37'h1_2345_6789, stream 3 words -> full 37-bit data preserved; post-reset out_data=37'h1_2345_6789.
